// File: rtl/dmem_responder_if.sv
// Load/store port between the MEM stage (master) and the data-memory responder (slave).
// Signal names keep the responder's _i/_o port view so existing connections map one-to-one.
interface dmem_responder_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 64
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [ADDR_W-1:0]     req_addr_i;
  logic [DATA_W-1:0]     req_wdata_i;
  logic [DATA_W/8-1:0]   req_wstrb_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_W-1:0]     rsp_rdata_o;
  logic                  rsp_write_o;
  logic                  rsp_err_o;

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_write_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_write_o, rsp_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-masked writes, fixed-latency reads, in-order responses
// through a fall-through queue guarded by an in-flight credit counter.
module dmem_responder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_responder_if.slave  bus
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int unsigned QI_W   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] RSP_FULL = CNT_W'(RSP_DEPTH);
  localparam logic [CNT_W-1:0] Q_LAST   = CNT_W'(RSP_DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [LATENCY-1:0] s_vld_q;
  logic [LATENCY-1:0] s_wr_q;
  logic [LATENCY-1:0] s_err_q;
  logic [DATA_W-1:0]  s_data_q [LATENCY];

  logic [DATA_W-1:0]  q_data_q [RSP_DEPTH];
  logic               q_wr_q   [RSP_DEPTH];
  logic               q_err_q  [RSP_DEPTH];

  logic [CNT_W-1:0] out_q,    out_d;
  logic [CNT_W-1:0] q_cnt_q,  q_cnt_d;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;

  logic              accept;
  logic              push;
  logic              pop;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [QI_W-1:0]   rd_idx;
  logic              rsp_vld;

  assign in_range = ({1'b0, bus.req_addr_i} < DEPTH_L);
  assign idx      = bus.req_addr_i[IDX_W-1:0];
  assign rd_idx   = rd_ptr_q[QI_W-1:0];

  assign bus.req_ready_o = (out_q < RSP_FULL);
  assign accept          = bus.req_valid_i & bus.req_ready_o;
  assign rsp_vld         = (q_cnt_q != '0);
  assign pop             = rsp_vld & bus.rsp_ready_i;
  assign push            = s_vld_q[LATENCY-1];

  assign bus.rsp_valid_o = rsp_vld;
  assign bus.rsp_rdata_o = rsp_vld ? q_data_q[rd_idx] : '0;
  assign bus.rsp_write_o = rsp_vld & q_wr_q[rd_idx];
  assign bus.rsp_err_o   = rsp_vld & q_err_q[rd_idx];

  always_comb begin
    out_d    = out_q;
    q_cnt_d  = q_cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (accept && !pop)      out_d = out_q + 1'b1;
    else if (!accept && pop) out_d = out_q - 1'b1;

    if (push && !pop)        q_cnt_d = q_cnt_q + 1'b1;
    else if (!push && pop)   q_cnt_d = q_cnt_q - 1'b1;

    if (push) wr_ptr_d = (wr_ptr_q == Q_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == Q_LAST) ? '0 : rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q    <= '0;
      q_cnt_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      s_vld_q  <= '0;
      s_wr_q   <= '0;
      s_err_q  <= '0;
    end else begin
      out_q      <= out_d;
      q_cnt_q    <= q_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      s_vld_q[0] <= accept;
      s_wr_q[0]  <= bus.req_write_i;
      s_err_q[0] <= ~in_range;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        s_vld_q[k] <= s_vld_q[k-1];
        s_wr_q[k]  <= s_wr_q[k-1];
        s_err_q[k] <= s_err_q[k-1];
      end
    end
  end

  // Array, data pipeline and queue payload carry no reset: contents survive rst_i and
  // stale payload is never visible because every output is qualified by a reset valid.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      if (bus.req_write_i && in_range) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (bus.req_wstrb_i[b]) mem_q[idx][b*8 +: 8] <= bus.req_wdata_i[b*8 +: 8];
        end
      end
      s_data_q[0] <= (!bus.req_write_i && in_range) ? mem_q[idx] : '0;
    end
    for (int unsigned k = 1; k < LATENCY; k++) begin
      s_data_q[k] <= s_data_q[k-1];
    end
    if (push) begin
      q_data_q[wr_ptr_q[QI_W-1:0]] <= s_data_q[LATENCY-1];
      q_wr_q[wr_ptr_q[QI_W-1:0]]   <= s_wr_q[LATENCY-1];
      q_err_q[wr_ptr_q[QI_W-1:0]]  <= s_err_q[LATENCY-1];
    end
  end
endmodule
